// File: rtl/wb_gpio_pkg.sv
// wb_gpio_pkg: register offsets and byte-lane helper shared by the GPIO block
package wb_gpio_pkg;
  localparam logic [2:0] GPIO_DATA_IN  = 3'd0;
  localparam logic [2:0] GPIO_DATA_OUT = 3'd1;
  localparam logic [2:0] GPIO_DIR      = 3'd2;
  localparam logic [2:0] GPIO_RISE_EN  = 3'd3;
  localparam logic [2:0] GPIO_FALL_EN  = 3'd4;
  localparam logic [2:0] GPIO_STATUS   = 3'd5;
  localparam logic [2:0] GPIO_TOGGLE   = 3'd6;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: input synchroniser chain plus one-cycle history for edge detection
module gpio_sync_edge #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  logic [WIDTH-1:0] r_chain [STAGES];
  logic [WIDTH-1:0] r_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
      r_prev <= '0;
    end else begin
      r_chain[0] <= d;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
      r_prev <= r_chain[STAGES-1];
    end
  assign sync = r_chain[STAGES-1];
  assign rise = sync & ~r_prev;
  assign fall = ~sync & r_prev;
endmodule

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone-classic GPIO with per-pin edge interrupts and one level irq
module wb_gpio_irq
  import wb_gpio_pkg::*;
#(
  parameter int               NGPIO       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [NGPIO-1:0] RESET_OUT   = '0,
  parameter logic [NGPIO-1:0] RESET_DIR   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      adr_i,
  input  logic [31:0]      dat_i,
  output logic [31:0]      dat_o,
  input  logic             we_i,
  input  logic [3:0]       sel_i,
  input  logic             stb_i,
  input  logic             cyc_i,
  output logic             ack_o,
  input  logic [NGPIO-1:0] gpio_i,
  output logic [NGPIO-1:0] gpio_o,
  output logic [NGPIO-1:0] gpio_oe_o,
  output logic             irq_o
);
  logic [NGPIO-1:0] r_out, r_dir, r_rise_en, r_fall_en, r_status;
  logic [NGPIO-1:0] w_sync, w_rise, w_fall, w_mask, w_wdat, w_w1c, w_status_nxt, w_rsel;
  logic [31:0]      w_lane;
  logic [2:0]       w_reg;
  logic             w_acc, w_wr, w_unused;

  gpio_sync_edge #(.WIDTH(NGPIO), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .d(gpio_i), .sync(w_sync), .rise(w_rise), .fall(w_fall)
  );

  assign w_acc  = cyc_i & stb_i & ~ack_o;
  assign w_wr   = w_acc & we_i;
  assign w_reg  = adr_i[4:2];
  assign w_lane = lane_mask(sel_i);
  assign w_mask = w_lane[NGPIO-1:0];
  assign w_wdat = dat_i[NGPIO-1:0] & w_mask;
  assign w_w1c  = (w_wr && w_reg == GPIO_STATUS) ? w_wdat : '0;
  // a fresh edge overrides a same-cycle clear of its bit
  assign w_status_nxt = (r_status & ~w_w1c) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_unused = ^{adr_i[31:5], adr_i[1:0], dat_i, w_lane};

  always_comb
    case (w_reg)
      GPIO_DATA_IN:  w_rsel = w_sync;
      GPIO_DATA_OUT: w_rsel = r_out;
      GPIO_DIR:      w_rsel = r_dir;
      GPIO_RISE_EN:  w_rsel = r_rise_en;
      GPIO_FALL_EN:  w_rsel = r_fall_en;
      GPIO_STATUS:   w_rsel = r_status;
      default:       w_rsel = '0;
    endcase

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_o     <= 1'b0;
      dat_o     <= '0;
      irq_o     <= 1'b0;
      r_out     <= RESET_OUT;
      r_dir     <= RESET_DIR;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
    end else begin
      ack_o    <= w_acc;
      r_status <= w_status_nxt;
      irq_o    <= |r_status;
      if (w_acc && !we_i) dat_o <= 32'(w_rsel);
      if (w_wr && w_reg == GPIO_DATA_OUT) r_out <= (r_out & ~w_mask) | w_wdat;
      if (w_wr && w_reg == GPIO_TOGGLE) r_out <= r_out ^ w_wdat;
      if (w_wr && w_reg == GPIO_DIR) r_dir <= (r_dir & ~w_mask) | w_wdat;
      if (w_wr && w_reg == GPIO_RISE_EN) r_rise_en <= (r_rise_en & ~w_mask) | w_wdat;
      if (w_wr && w_reg == GPIO_FALL_EN) r_fall_en <= (r_fall_en & ~w_mask) | w_wdat;
    end

  assign gpio_o    = r_out;
  assign gpio_oe_o = r_dir;
endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb_wb_gpio_irq: directed Wishbone and pin stimulus against hand-computed expectations
module tb_wb_gpio_irq;
  import wb_gpio_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] adr = '0, wdat = '0, dat_o;
  logic        we = 1'b0, stb = 1'b0, cyc = 1'b0, ack_o, irq_o;
  logic [3:0]  sel = '0;
  logic [7:0]  gpio = '0, gpio_o, gpio_oe_o;
  logic [31:0] rdat;
  logic        ia;
  int          vecs = 0, errs = 0;

  wb_gpio_irq #(.NGPIO(8), .SYNC_STAGES(2), .RESET_OUT(8'hA5), .RESET_DIR(8'h0F)) dut (
    .clk(clk), .rst_n(rst_n), .adr_i(adr), .dat_i(wdat), .dat_o(dat_o), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack_o), .gpio_i(gpio),
    .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic [2:0] r, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] q, output logic irq_ack);
    @(negedge clk);
    adr = {27'd0, r, 2'b00}; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("ack_hi", ack_o, 1);
    q = dat_o;
    irq_ack = irq_o;
    @(posedge clk); #1;
    chk("ack_lo", ack_o, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s = 4'hF);
    xfer(r, 1'b1, d, s, rdat, ia);
  endtask

  task automatic rd(input logic [2:0] r);
    xfer(r, 1'b0, 32'd0, 4'hF, rdat, ia);
  endtask

  initial begin
    gpio = 8'h3C;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack_o, 0);
    chk("rst_irq", irq_o, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_oe", gpio_oe_o, 8'h0F);
    chk("rst_out", gpio_o, 8'hA5);
    @(negedge clk) rst_n = 1'b1;
    rd(GPIO_DATA_OUT); chk("rd_out_rst", rdat, 32'hA5);
    rd(GPIO_DIR);      chk("rd_dir_rst", rdat, 32'h0F);
    wr(GPIO_RISE_EN, 32'hFF);
    repeat (5) @(posedge clk);
    #1;
    chk("held_irq", irq_o, 0);
    rd(GPIO_STATUS);  chk("held_status", rdat, 0);
    rd(GPIO_DATA_IN); chk("data_in", rdat, 32'h3C);
    wr(GPIO_RISE_EN, 32'h01);
    @(negedge clk) gpio = 8'h00;
    repeat (5) @(posedge clk);
    rd(GPIO_STATUS);  chk("no_fall_status", rdat, 0);

    wr(GPIO_DATA_OUT, 32'hFF, 4'b0001); chk("out_lane0", gpio_o, 8'hFF);
    wr(GPIO_TOGGLE, 32'h0F);            chk("toggle", gpio_o, 8'hF0);
    wr(GPIO_DATA_OUT, 32'h0, 4'b1110);  chk("out_lane_off", gpio_o, 8'hF0);
    wr(GPIO_TOGGLE, 32'hFF, 4'b0010);   chk("toggle_lane_off", gpio_o, 8'hF0);
    rd(GPIO_TOGGLE);  chk("rd_toggle", rdat, 0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7);         chk("rd_rsvd", rdat, 0);
    rd(GPIO_DATA_OUT); chk("rd_out", rdat, 32'hF0);
    wr(GPIO_DIR, 32'hFFFF_FF3C);
    chk("dat_hold", rdat, 32'hF0);
    chk("oe", gpio_oe_o, 8'h3C);
    rd(GPIO_DIR);     chk("rd_dir_upper", rdat, 32'h3C);

    @(negedge clk) gpio = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    chk("irq_pre", irq_o, 0);
    @(posedge clk); #1;
    chk("irq_rise", irq_o, 1);
    rd(GPIO_STATUS);  chk("status_rise", rdat, 32'h01);
    @(negedge clk) gpio = 8'h00;
    repeat (5) @(posedge clk);
    rd(GPIO_STATUS);  chk("status_fall_ign", rdat, 32'h01);
    wr(GPIO_STATUS, 32'h01);
    chk("w1c0_irq", irq_o, 0);

    wr(GPIO_FALL_EN, 32'h80);
    @(negedge clk) gpio = 8'h80;
    repeat (5) @(posedge clk);
    #1;
    chk("rise7_masked", irq_o, 0);
    @(negedge clk) gpio = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("irq_fall7", irq_o, 1);
    rd(GPIO_STATUS);  chk("status_fall7", rdat, 32'h80);
    wr(GPIO_STATUS, 32'h80);
    chk("w1c7_irq_ack", ia, 1);
    chk("w1c7_irq_drop", irq_o, 0);
    rd(GPIO_STATUS);  chk("status_clr7", rdat, 0);

    @(negedge clk) gpio = 8'h01;
    repeat (5) @(posedge clk);
    @(negedge clk) gpio = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("irq_pre_race", irq_o, 1);
    @(negedge clk) gpio = 8'h01;
    repeat (2) @(posedge clk);
    wr(GPIO_STATUS, 32'h01);
    chk("race_irq_ack", ia, 1);
    chk("race_irq", irq_o, 1);
    rd(GPIO_STATUS);  chk("race_status", rdat, 32'h01);
    wr(GPIO_STATUS, 32'h01);
    rd(GPIO_STATUS);  chk("race_clr", rdat, 0);

    @(negedge clk);
    adr = {27'd0, GPIO_DATA_OUT, 2'b00}; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("mid_ack", ack_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack_o, 0);
    chk("mid_rst_out", gpio_o, 8'hA5);
    chk("mid_rst_oe", gpio_oe_o, 8'h0F);
    cyc = 1'b0; stb = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
